// File: rtl/multi_channel_range_converter_pkg.sv
// Shared state encoding and elaboration-time helpers for the multi-channel
// range converter and its sequential divider.
package multi_channel_range_converter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIVIDE,
    S_STORE,
    S_DONE
  } state_e;

  // Width needed to index n items; never narrower than one bit.
  function automatic int f_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int f_num_width(input int inWidth, input int outWidth);
    return inWidth + outWidth + 1;
  endfunction

  function automatic int f_span(input int lo, input int hi);
    return hi - lo;
  endfunction

endpackage

// File: rtl/multi_channel_range_converter_seq_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; o_Done is high
// during the final iteration, so quotient/remainder are valid the cycle after.
module seq_divider
  import multi_channel_range_converter_pkg::*;
#(
  parameter int g_Width = 13
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Start,
  input  logic [g_Width-1:0] i_Dividend,
  input  logic [g_Width-1:0] i_Divisor,
  output logic               o_Busy,
  output logic               o_Done,
  output logic [g_Width-1:0] o_Quotient,
  output logic [g_Width-1:0] o_Remainder
);

  localparam int c_Cnt_Width = f_clog2(g_Width + 1);

  logic                   busy_q, busy_d;
  logic [c_Cnt_Width-1:0] cnt_q, cnt_d;
  logic [g_Width-1:0]     rem_q, rem_d;
  logic [g_Width-1:0]     quo_q, quo_d;
  logic [g_Width-1:0]     div_q, div_d;
  logic [g_Width:0]       trial;

  // The quotient register doubles as the shift source for the dividend bits.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    trial  = {rem_q, quo_q[g_Width-1]};
    if (i_Start) begin
      busy_d = 1'b1;
      cnt_d  = c_Cnt_Width'(g_Width);
      rem_d  = '0;
      quo_d  = i_Dividend;
      div_d  = i_Divisor;
    end else if (busy_q) begin
      if (trial >= {1'b0, div_q}) begin
        rem_d = g_Width'(trial - {1'b0, div_q});
        quo_d = {quo_q[g_Width-2:0], 1'b1};
      end else begin
        rem_d = trial[g_Width-1:0];
        quo_d = {quo_q[g_Width-2:0], 1'b0};
      end
      cnt_d = cnt_q - c_Cnt_Width'(1);
      if (cnt_q == c_Cnt_Width'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
    end
  end

  assign o_Busy      = busy_q;
  assign o_Done      = busy_q && (cnt_q == c_Cnt_Width'(1));
  assign o_Quotient  = quo_q;
  assign o_Remainder = rem_q;

endmodule

// File: rtl/multi_channel_range_converter.sv
// Rescales g_Channels packed unsigned samples from the old range to the new
// range, one channel at a time through a shared sequential divider.
module multi_channel_range_converter
  import multi_channel_range_converter_pkg::*;
#(
  parameter int g_Channels  = 4,
  parameter int g_In_Width  = 8,
  parameter int g_Out_Width = 4,
  parameter int g_Old_Min   = 10,
  parameter int g_Old_Max   = 100,
  parameter int g_New_Min   = 0,
  parameter int g_New_Max   = 15,
  parameter int g_Round     = 0
) (
  input  logic                              i_Clk,
  input  logic                              i_Rst,
  input  logic                              i_Valid,
  output logic                              o_Ready,
  input  logic [g_Channels*g_In_Width-1:0]  i_Old_Values,
  output logic [g_Channels*g_Out_Width-1:0] o_New_Values,
  output logic                              o_Valid
);

  localparam int c_Num_Width = f_num_width(g_In_Width, g_Out_Width);
  localparam int c_D         = f_span(g_Old_Min, g_Old_Max);
  localparam int c_R         = f_span(g_New_Min, g_New_Max);
  localparam int c_Idx_Width = f_clog2(g_Channels);

  localparam logic [g_In_Width-1:0]  c_Old_Min   = g_In_Width'(g_Old_Min);
  localparam logic [g_In_Width-1:0]  c_Old_Max   = g_In_Width'(g_Old_Max);
  localparam logic [c_Num_Width-1:0] c_D_N       = c_Num_Width'(c_D);
  localparam logic [c_Num_Width-1:0] c_R_N       = c_Num_Width'(c_R);
  localparam logic [c_Num_Width-1:0] c_Half_N    = (g_Round != 0) ? c_Num_Width'(c_D / 2) : '0;
  localparam logic [c_Num_Width-1:0] c_New_Min_N = c_Num_Width'(g_New_Min);
  localparam logic [c_Idx_Width-1:0] c_Last_Idx  = c_Idx_Width'(g_Channels - 1);

  state_e                            state_q, state_d;
  logic [c_Idx_Width-1:0]            idx_q, idx_d;
  logic [g_Channels*g_In_Width-1:0]  samples_q, samples_d;
  logic [g_Channels*g_Out_Width-1:0] staging_q, staging_d;
  logic [g_Channels*g_Out_Width-1:0] result_q, result_d;
  logic                              valid_q, valid_d;

  logic [g_In_Width-1:0]  sample;
  logic [g_In_Width-1:0]  clamped;
  logic [g_In_Width-1:0]  offset;
  logic [c_Num_Width-1:0] numerator;
  logic [g_Out_Width-1:0] storeValue;
  logic                   divStart;
  logic                   divBusy;
  logic                   divDone;
  logic [c_Num_Width-1:0] divQuotient;
  logic [c_Num_Width-1:0] divRemainder;
  logic                   unusedDiv;

  // Numerator for the channel selected by idx_q; the product always fits
  // because D*R + D/2 stays below 2^(In+Out).
  always_comb begin
    sample = samples_q[int'(idx_q)*g_In_Width +: g_In_Width];
    if (sample <= c_Old_Min) begin
      clamped = c_Old_Min;
    end else if (sample >= c_Old_Max) begin
      clamped = c_Old_Max;
    end else begin
      clamped = sample;
    end
    offset    = clamped - c_Old_Min;
    numerator = c_Num_Width'(offset) * c_R_N + c_Half_N;
  end

  assign divStart   = (state_q == S_LOAD);
  assign storeValue = g_Out_Width'(divQuotient + c_New_Min_N);
  assign unusedDiv  = ^{divBusy, divRemainder};

  seq_divider #(
    .g_Width(c_Num_Width)
  ) u_divider (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Start    (divStart),
    .i_Dividend (numerator),
    .i_Divisor  (c_D_N),
    .o_Busy     (divBusy),
    .o_Done     (divDone),
    .o_Quotient (divQuotient),
    .o_Remainder(divRemainder)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    samples_d = samples_q;
    staging_d = staging_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_Valid) begin
          samples_d = i_Old_Values;
          idx_d     = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD:   state_d = S_DIVIDE;
      S_DIVIDE: begin
        if (divDone) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        staging_d[int'(idx_q)*g_Out_Width +: g_Out_Width] = storeValue;
        if (idx_q == c_Last_Idx) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + c_Idx_Width'(1);
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        result_d = staging_q;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      samples_q <= '0;
      staging_q <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      samples_q <= samples_d;
      staging_q <= staging_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

  assign o_Ready      = (state_q == S_IDLE);
  assign o_Valid      = valid_q;
  assign o_New_Values = result_q;

endmodule

// File: doc/multi_channel_range_converter.md
Name: multi_channel_range_converter

Overview:
Parametrised successor to the single-channel range converter with its external divider. Linearly rescales g_Channels unsigned samples from [g_Old_Min, g_Old_Max] to [g_New_Min, g_New_Max]. Adds input clamping, optional round-to-nearest and a valid/ready handshake. Uses one internal shared sequential divider, and all channels are processed one after another per transaction.

Parameters:
g_Channels, 4, number of channels packed on the input and output buses (>=1)
g_In_Width, 8, bits per input sample
g_Out_Width, 4, bits per output sample
g_Old_Min, 10, lower bound of the input range
g_Old_Max, 100, upper bound of the input range (must be > g_Old_Min and < 2^g_In_Width)
g_New_Min, 0, lower bound of the output range
g_New_Max, 15, upper bound of the output range (must be >= g_New_Min and < 2^g_Out_Width)
g_Round, 0, 0 = truncate (floor), 1 = round half up

Ports:
i_Clk  in  1  system clock; one clock domain only
i_Rst  in  1  reset, synchronous and active-high
i_Valid  in  1  input samples are valid
o_Ready  out  1  block is idle and can accept a transaction
i_Old_Values  in  g_Channels*g_In_Width  packed samples; channel 0 in the LSBs
o_New_Values  out  g_Channels*g_Out_Width  packed results; channel 0 in the LSBs
o_Valid  out  1  one-cycle pulse: o_New_Values has been updated

Behaviour:
- Arithmetic per channel:
  - x = clamp(in, g_Old_Min, g_Old_Max)
  - N = (x - g_Old_Min) * (g_New_Max - g_New_Min), plus D/2 (floor) when g_Round = 1
  - D = g_Old_Max - g_Old_Min
  - out = N / D + g_New_Min (integer division)
- Widths and bounds:
  - Numerator width c_Num_Width = g_In_Width + g_Out_Width + 1.
  - Out can never exceed g_New_Max, so no output saturation logic is needed.
- Handshake:
  - A transaction is accepted on the edge where i_Valid && o_Ready.
  - All input channels are captured in an internal register on that edge.
  - i_Valid while o_Ready = 0 is ignored; there is no queueing.
- State machine IDLE, LOAD, DIVIDE, STORE, DONE:
  - IDLE: o_Ready = 1. On accept, go to LOAD with channel index = 0.
  - LOAD (1 cycle): clamp, subtract, multiply and round for the current channel. Load the divider.
  - DIVIDE (c_Num_Width cycles): restoring divide, 1 quotient bit per cycle, MSB first.
  - STORE (1 cycle): add g_New_Min and write the result into the staging register slot. If index = g_Channels-1, go to DONE; else increment the index and go to LOAD.
  - DONE (1 cycle): copy the staging register to o_New_Values, pulse o_Valid, return to IDLE.
- Latency:
  - Accept edge to o_Valid high = g_Channels*(c_Num_Width+2) + 1 cycles.
  - Defaults: 4*15 + 1 = 61 cycles.
- o_Ready and o_Valid:
  - o_Ready is low from the cycle after accept through DONE.
  - o_Ready is high again in the cycle after DONE, so back-to-back throughput is one transaction per latency + 1 cycles.
  - o_New_Values holds its value between transactions and changes only in DONE.
- Reset, taking priority over all other activity:
  - state = IDLE, o_Ready = 1, o_Valid = 0.
  - o_New_Values = 0, staging register and divider registers = 0, index = 0.
  - Reset mid-transaction aborts it: no o_Valid pulse and o_New_Values is unchanged from 0.
- Boundaries:
  - in <= g_Old_Min -> g_New_Min.
  - in >= g_Old_Max -> g_New_Max.
  - g_New_Max = g_New_Min -> constant output.
  - g_Channels = 1 is legal.
  - Input changes after accept have no effect on the transaction in progress.

Decomposition:
- Shared package holds:
  - state encoding constants
  - c_Num_Width
  - constants D and R = g_New_Max - g_New_Min
  - clog2 helper for the channel index width
- Single sub-module seq_divider: parametrised restoring divider with start/busy/done pulse, quotient and remainder outputs, and the same clock and reset. It replaces the previous external divider.

Test Plan:
- Defaults, channels = {70, 10, 100, 55}, g_Round = 0 -> o_New_Values = {10, 0, 15, 7}; o_Valid exactly 61 cycles after the accept edge.
- Clamping: inputs {0, 5, 200, 255} -> {0, 0, 15, 15}.
- Rounding: g_Round = 1, inputs {55, 16, 70, 94} -> {8, 1, 10, 14}; with g_Round = 0 the same inputs give {7, 1, 10, 14}.
- Handshake: hold i_Valid high continuously with changing data -> only samples present on cycles with o_Ready = 1 are processed; mid-busy values are ignored; one o_Valid pulse per accept.
- Reset at cycle 30 of a transaction -> no o_Valid; outputs = 0; o_Ready = 1 the cycle after reset; the next transaction completes correctly.
- g_Channels = 1, g_In_Width = 12, g_Old_Min = 0, g_Old_Max = 4095, g_New_Max = 255 -> input 2048 gives 127; exhaustive sweep of all 4096 inputs against a reference model.
